// File: rtl/ow_txn_sequencer.sv
// One-wire bus master: reset pulse, presence detect, LSB-first command byte, optional read byte.
// Define OW_RX_TIMEOUT_EN to abandon the receiver wait after RX_TIMEOUT cycles.
module ow_txn_sequencer #(
  parameter int unsigned RST_LOW     = 480,
  parameter int unsigned PRES_SAMPLE = 70,
  parameter int unsigned RST_TOTAL   = 960,
  parameter int unsigned SLOT        = 71,
  parameter int unsigned WR0_LOW     = 60,
  parameter int unsigned WR1_LOW     = 6
`ifdef OW_RX_TIMEOUT_EN
  ,
  parameter int unsigned RX_TIMEOUT  = 600
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] cmd_byte,
  input  logic       read_en,
  input  logic       bus_in,
  output logic       bus_oe,
  output logic       rx_en,
  input  logic       rx_done,
  input  logic [7:0] rx_frame,
  output logic       busy,
  output logic       done,
  output logic       presence,
  output logic       error,
  output logic [7:0] data_out
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StRstPulse = 3'd1;
  localparam logic [2:0] StPres     = 3'd2;
  localparam logic [2:0] StTxBit    = 3'd3;
  localparam logic [2:0] StRxWait   = 3'd4;
  localparam logic [2:0] StFinish   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shreg_q;
  logic        read_en_q;
  logic        rx_done_q;
  logic        busy_q;
  logic        presence_q;
  logic        error_q;
  logic [7:0]  data_out_q;

  logic        rx_edge;
  logic        rst_end;
  logic        pres_end;
  logic        slot_end;
  logic [15:0] low_time;

  assign rx_edge  = rx_done & ~rx_done_q;
  assign rst_end  = cnt_q == 16'(RST_LOW - 1);
  assign pres_end = cnt_q == 16'(RST_TOTAL - RST_LOW - 1);
  assign slot_end = cnt_q == 16'(SLOT - 1);
  assign low_time = shreg_q[0] ? 16'(WR1_LOW) : 16'(WR0_LOW);

`ifdef OW_RX_TIMEOUT_EN
  logic rx_timeout;
  assign rx_timeout = cnt_q == 16'(RX_TIMEOUT - 1);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (start) state_d = StRstPulse;
      StRstPulse: if (rst_end) state_d = StPres;
      StPres:     if (pres_end) state_d = presence_q ? StTxBit : StFinish;
      StTxBit:    if (slot_end && bit_idx_q == 3'd7) state_d = read_en_q ? StRxWait : StFinish;
      StRxWait: begin
        if (rx_edge) state_d = StFinish;
`ifdef OW_RX_TIMEOUT_EN
        else if (rx_timeout) state_d = StFinish;
`endif
      end
      StFinish:   state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Drive from state so an asynchronous reset releases the bus at once.
  always_comb begin
    bus_oe = 1'b0;
    case (state_q)
      StRstPulse: bus_oe = 1'b1;
      StTxBit:    bus_oe = cnt_q < low_time;
      default:    bus_oe = 1'b0;
    endcase
  end

  assign rx_en    = state_q == StRxWait;
  assign done     = state_q == StFinish;
  assign busy     = busy_q;
  assign presence = presence_q;
  assign error    = error_q;
  assign data_out = data_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 16'd0;
      bit_idx_q  <= 3'd0;
      shreg_q    <= 8'h00;
      read_en_q  <= 1'b0;
      rx_done_q  <= 1'b0;
      busy_q     <= 1'b0;
      presence_q <= 1'b0;
      error_q    <= 1'b0;
      data_out_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      rx_done_q <= rx_done;
      // Each write slot restarts the counter even though the state is unchanged.
      if (state_d != state_q || (state_q == StTxBit && slot_end)) begin
        cnt_q <= 16'd0;
      end else if (state_q != StIdle) begin
        cnt_q <= cnt_q + 16'd1;
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            shreg_q   <= cmd_byte;
            read_en_q <= read_en;
            busy_q    <= 1'b1;
            error_q   <= 1'b0;
            bit_idx_q <= 3'd0;
          end
        end
        StPres: begin
          if (cnt_q == 16'(PRES_SAMPLE)) presence_q <= ~bus_in;
          if (pres_end && !presence_q) error_q <= 1'b1;
          bit_idx_q <= 3'd0;
        end
        StTxBit: begin
          if (slot_end) begin
            shreg_q   <= {1'b0, shreg_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
        StRxWait: begin
          if (rx_edge) data_out_q <= rx_frame;
`ifdef OW_RX_TIMEOUT_EN
          else if (rx_timeout) error_q <= 1'b1;
`endif
        end
        StFinish: busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
